// File: rtl/ntt_bfu_pipe.sv
// Pipelined radix-2 NTT/INTT butterfly: Cooley-Tukey or Gentleman-Sande selected per sample,
// one shared Barrett multiplier, fixed latency LAT = MUL_STAGES + 2 enabled cycles.

module ntt_bfu_modmul #(
  parameter int DW         = 16,
  parameter int Q          = 12289,
  parameter int MUL_STAGES = 3
) (
  input  logic          clk,
  input  logic          en,
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] res_o
);
  localparam int PW  = 2 * DW;
  localparam int PW2 = 2 * PW;
  localparam int RW  = DW + 2;
  localparam logic [PW:0]   ONE_S = (PW+1)'(1) << PW;
  localparam logic [PW-1:0] MU    = PW'(ONE_S / (PW+1)'(Q));
  localparam logic [RW-1:0] QR    = RW'(Q);
  localparam logic [RW-1:0] Q2R   = RW'(2 * Q);
  // Register placement after step {correct, reduce, quotient, product}
  localparam logic [3:0] RB = (MUL_STAGES == 1) ? 4'b1000 :
                              (MUL_STAGES == 2) ? 4'b1001 :
                              (MUL_STAGES == 3) ? 4'b1101 : 4'b1111;

  logic [PW-1:0] p_c, p_s;
  logic [RW-1:0] qh_c, qh_s, pl_c, pl_s, r_c, r_s, rc;
  logic [DW-1:0] res_q;

  assign p_c = PW'(a_i) * PW'(b_i);
  if (RB[0]) begin : g_p_reg
    logic [PW-1:0] p_q;
    always_ff @(posedge clk) if (en) p_q <= p_c;
    assign p_s = p_q;
  end else begin : g_p_wire
    assign p_s = p_c;
  end

  // Barrett error is at most 2Q, so only the low RW bits of p and the quotient matter
  assign qh_c = RW'((PW2'(p_s) * PW2'(MU)) >> PW);
  assign pl_c = RW'(p_s);
  if (RB[1]) begin : g_q_reg
    logic [RW-1:0] qh_q, pl_q;
    always_ff @(posedge clk) if (en) begin
      qh_q <= qh_c;
      pl_q <= pl_c;
    end
    assign qh_s = qh_q;
    assign pl_s = pl_q;
  end else begin : g_q_wire
    assign qh_s = qh_c;
    assign pl_s = pl_c;
  end

  assign r_c = pl_s - qh_s * QR;
  if (RB[2]) begin : g_r_reg
    logic [RW-1:0] r_q;
    always_ff @(posedge clk) if (en) r_q <= r_c;
    assign r_s = r_q;
  end else begin : g_r_wire
    assign r_s = r_c;
  end

  always_comb begin
    rc = r_s;
    if (r_s >= Q2R)     rc = r_s - Q2R;
    else if (r_s >= QR) rc = r_s - QR;
  end

  always_ff @(posedge clk) if (en) res_q <= DW'(rc);
  assign res_o = res_q;
endmodule

module ntt_bfu_pipe #(
  parameter int DW         = 16,
  parameter int Q          = 12289,
  parameter int MUL_STAGES = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          mode,
  input  logic [DW-1:0] xin,
  input  logic [DW-1:0] yin,
  input  logic [DW-1:0] wr,
  output logic [DW-1:0] xout,
  output logic [DW-1:0] yout,
  output logic          valid,
  output logic          busy
);
  localparam int LAT = MUL_STAGES + 2;
  localparam logic [DW:0] QE = (DW+1)'(Q);

  function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= QE) s = s - QE;
    return DW'(s);
  endfunction

  function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (d[DW]) d = d + QE;
    return DW'(d);
  endfunction

  // vld_q[0]: input stage, [1..MUL_STAGES]: multiplier, [LAT-1]: output
  logic [LAT-1:0] vld_q, vld_d;
  logic [DW-1:0]  x0_q, y0_q, w0_q;
  logic           m0_q;
  logic [DW-1:0]  gs_sum, gs_dif, mul_a, side_d, t;
  logic [MUL_STAGES-1:0][DW-1:0] sx_q;
  logic [MUL_STAGES-1:0]         sm_q;
  logic [DW-1:0]  xo_q, xo_d, yo_q, yo_d;

  assign vld_d = {vld_q[LAT-2:0], 1'b1};

  always_ff @(posedge clk) begin
    if (reset)   vld_q <= '0;
    else if (en) vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      x0_q <= xin;
      y0_q <= yin;
      w0_q <= wr;
      m0_q <= mode;
    end
  end

  // GS add/sub is folded in front of the shared multiplier so both modes see the same depth
  assign gs_sum = mod_add(x0_q, y0_q);
  assign gs_dif = mod_sub(x0_q, y0_q);
  assign mul_a  = m0_q ? gs_dif : y0_q;
  assign side_d = m0_q ? gs_sum : x0_q;

  ntt_bfu_modmul #(.DW(DW), .Q(Q), .MUL_STAGES(MUL_STAGES)) u_mul (
    .clk   (clk),
    .en    (en),
    .a_i   (mul_a),
    .b_i   (w0_q),
    .res_o (t)
  );

  always_ff @(posedge clk) begin
    if (en) begin
      sx_q[0] <= side_d;
      sm_q[0] <= m0_q;
      for (int i = 1; i < MUL_STAGES; i++) begin
        sx_q[i] <= sx_q[i-1];
        sm_q[i] <= sm_q[i-1];
      end
    end
  end

  always_comb begin
    xo_d = xo_q;
    yo_d = yo_q;
    if (vld_q[MUL_STAGES]) begin
      if (sm_q[MUL_STAGES-1]) begin
        xo_d = sx_q[MUL_STAGES-1];
        yo_d = t;
      end else begin
        xo_d = mod_add(sx_q[MUL_STAGES-1], t);
        yo_d = mod_sub(sx_q[MUL_STAGES-1], t);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      xo_q <= '0;
      yo_q <= '0;
    end else if (en) begin
      xo_q <= xo_d;
      yo_q <= yo_d;
    end
  end

  assign xout  = xo_q;
  assign yout  = yo_q;
  assign valid = vld_q[LAT-1];
  assign busy  = |vld_q;
endmodule

// File: tb/tb_ntt_bfu_pipe.sv
// Directed vector bench for ntt_bfu_pipe (DW=16, Q=12289, MUL_STAGES=3, LAT=5).

module tb_ntt_bfu_pipe;
  localparam int DW  = 16;
  localparam int Q   = 12289;
  localparam int MS  = 3;
  localparam int LAT = MS + 2;

  typedef struct {
    logic          m;
    logic [DW-1:0] x, y, w, ex, ey;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset, en, mode;
  logic [DW-1:0] xin, yin, wr, xout, yout;
  logic          valid, busy;

  int checks = 0;
  int errors = 0;

  // reference: expected results travelling with their valid flag
  logic [LAT-1:0] mv;
  logic [DW-1:0]  mx [LAT];
  logic [DW-1:0]  my [LAT];
  logic [DW-1:0]  ox, oy;

  always #5 clk = ~clk;

  ntt_bfu_pipe #(.DW(DW), .Q(Q), .MUL_STAGES(MS)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .mode  (mode),
    .xin   (xin),
    .yin   (yin),
    .wr    (wr),
    .xout  (xout),
    .yout  (yout),
    .valid (valid),
    .busy  (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic m,
                      input logic [DW-1:0] x, input logic [DW-1:0] y, input logic [DW-1:0] w,
                      input logic [DW-1:0] ex, input logic [DW-1:0] ey, input string tag);
    reset = r; en = e; mode = m; xin = x; yin = y; wr = w;
    @(posedge clk);
    if (r) begin
      mv = '0; ox = '0; oy = '0;
    end else if (e) begin
      if (mv[LAT-2]) begin
        ox = mx[LAT-2];
        oy = my[LAT-2];
      end
      for (int i = LAT-1; i > 0; i--) begin
        mx[i] = mx[i-1];
        my[i] = my[i-1];
      end
      mv = {mv[LAT-2:0], 1'b1};
      mx[0] = ex;
      my[0] = ey;
    end
    #1;
    chk({tag, " valid"}, 32'(valid), 32'(mv[LAT-1]));
    chk({tag, " busy"},  32'(busy),  32'(|mv));
    chk({tag, " xout"},  32'(xout),  32'(ox));
    chk({tag, " yout"},  32'(yout),  32'(oy));
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0, '0, "fill");
  endtask

  initial begin
    vec_t tbl [12];
    logic m;
    tbl[0]  = '{1'b0, 16'd1,     16'd2,     16'd3,     16'd7,     16'd12284};
    tbl[1]  = '{1'b1, 16'd5,     16'd7,     16'd2,     16'd12,    16'd12285};
    tbl[2]  = '{1'b0, 16'd12288, 16'd12288, 16'd12288, 16'd0,     16'd12287};
    tbl[3]  = '{1'b0, 16'd0,     16'd1,     16'd1,     16'd1,     16'd12288};
    tbl[4]  = '{1'b0, 16'd10,    16'd3,     16'd4,     16'd22,    16'd12287};
    tbl[5]  = '{1'b1, 16'd10,    16'd3,     16'd4,     16'd13,    16'd28};
    tbl[6]  = '{1'b1, 16'd12288, 16'd0,     16'd12288, 16'd12288, 16'd1};
    tbl[7]  = '{1'b1, 16'd0,     16'd12288, 16'd5,     16'd12288, 16'd5};
    tbl[8]  = '{1'b0, 16'd100,   16'd200,   16'd300,   16'd10944, 16'd1545};
    tbl[9]  = '{1'b1, 16'd12000, 16'd500,   16'd7,     16'd211,   16'd6766};
    tbl[10] = '{1'b0, 16'd12288, 16'd1,     16'd12288, 16'd12287, 16'd0};
    tbl[11] = '{1'b0, 16'd5,     16'd12287, 16'd12287, 16'd9,     16'd1};

    mv = '0; ox = '0; oy = '0;
    for (int i = 0; i < LAT; i++) begin
      mx[i] = '0;
      my[i] = '0;
    end

    // reset state, then CT basic latency by hand
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0, "reset");
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset xout", 32'(xout), 32'd0);
    step(1'b0, 1'b1, 1'b0, 16'd1, 16'd2, 16'd3, 16'd7, 16'd12284, "ct_basic");
    fill(3);
    chk("ct_basic pre valid", 32'(valid), 32'd0);
    fill(1);
    chk("ct_basic valid", 32'(valid), 32'd1);
    chk("ct_basic xout", 32'(xout), 32'd7);
    chk("ct_basic yout", 32'(yout), 32'd12284);

    // table vectors streamed back to back
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0, "reset");
    for (int i = 0; i < 12; i++)
      step(1'b0, 1'b1, tbl[i].m, tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].ex, tbl[i].ey, "table");
    fill(LAT);

    // stall with empty output, then stall with a live output
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0, "reset");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, DW'(i), 16'd1, 16'd1, DW'(i + 1), DW'((i + Q - 1) % Q), "stream");
      if (i == 2 || i == 5)
        for (int k = 0; k < 3; k++)
          step(1'b0, 1'b0, 1'b1, 16'd999, 16'd5, 16'd7, '0, '0, "stall");
    end
    fill(LAT);

    // alternating modes, one result per cycle
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0, "reset");
    for (int i = 0; i < 8; i++) begin
      m = (i % 2) == 1;
      step(1'b0, 1'b1, m, 16'd10, 16'd3, 16'd4, m ? 16'd13 : 16'd22, m ? 16'd28 : 16'd12287, "mixed");
    end
    fill(LAT);

    // reset mid-flight with a live output; the sample offered with reset is dropped
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0, "reset");
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'b0, DW'(i + 20), 16'd1, 16'd1, DW'(i + 21), DW'(i + 19), "pre");
    step(1'b0, 1'b1, 1'b0, 16'd1, 16'd2, 16'd3, 16'd7, 16'd12284, "midA");
    step(1'b1, 1'b1, 1'b1, 16'd5, 16'd7, 16'd2, '0, '0, "midrst");
    chk("midrst valid", 32'(valid), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst xout", 32'(xout), 32'd0);
    chk("midrst yout", 32'(yout), 32'd0);
    step(1'b0, 1'b1, 1'b1, 16'd5, 16'd7, 16'd2, 16'd12, 16'd12285, "midC");
    fill(LAT - 1);
    chk("after_rst valid", 32'(valid), 32'd1);
    chk("after_rst xout", 32'(xout), 32'd12);
    chk("after_rst yout", 32'(yout), 32'd12285);
    fill(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ntt_bfu_pipe.md
Name: ntt_bfu_pipe

Overview:
Parametrised, fully pipelined radix-2 NTT/INTT butterfly unit. It is the next generation of the fixed-width NTT2 pipeline. It adds a generic data width and modulus, a configurable multiplier depth, and a per-sample mode select: Cooley-Tukey for forward NTT and Gentleman-Sande for inverse NTT. It sits between the coefficient memory read ports and the write-back path of the NTT core, and accepts one butterfly per enabled cycle.

Parameters:
DW, 16, coefficient/twiddle width in bits; all data ports are DW bits wide.
Q, 12289, prime modulus. Must satisfy 2 < Q < 2^DW.
MUL_STAGES, 3, register stages inside the modular multiplier (product, reduce, final correct). Legal range 1..4.
LAT, MUL_STAGES+2, derived and not overridable; input-to-output latency in enabled cycles.

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
en  in  1  pipeline advance and input-valid qualifier
mode  in  1  0 = CT (forward NTT), 1 = GS (inverse NTT); sampled with the data
xin  in  DW  operand x, required < Q
yin  in  DW  operand y, required < Q
wr  in  DW  twiddle factor w, required < Q
xout  out  DW  result x'
yout  out  DW  result y'
valid  out  1  xout/yout hold a result this cycle
busy  out  1  at least one sample in flight (any internal valid bit set)

Behaviour:
- Arithmetic (all mod Q, results in [0, Q-1]):
  - CT: t = w*y mod Q; x' = (x + t) mod Q; y' = (x - t) mod Q.
  - GS: x' = (x + y) mod Q; y' = ((x - y) mod Q) * w mod Q.
- Add/sub rule: compute in DW+1 bits, then one conditional correction (subtract Q if sum >= Q; add Q if difference is negative). No `%` operator on a non-constant value.
- Modular multiply: the 2*DW-bit product is reduced by Barrett with constants precomputed from Q at elaboration. It is spread over MUL_STAGES registers and its output is fully reduced.
- Pipeline structure, identical depth for both modes:
  - Stage 0 registers inputs and mode.
  - CT: multiplier stages, then one add/sub stage.
  - GS: one add/sub stage, then multiplier stages. x' is delayed alongside the multiplier stages.
  - A single shared multiplier is muxed by the per-stage mode bit. Two instances are also acceptable if the latency is equal.
- Latency: a sample presented with en=1 at edge k appears on xout/yout with valid=1 after LAT enabled edges. Disabled cycles do not count.
- en=0: every pipeline register, including valid bits, holds its value. Outputs and valid stay frozen (stall, not bubble). A sample cannot be inserted while en=0.
- Bubbles: the valid bit travels with each sample. A stage whose input was not captured (pipeline drained) carries valid=0. Its data is don't-care, but xout/yout must not change while valid=0 at the output; the output registers load only when the incoming valid is 1.
- Mode changes take effect per sample. Back-to-back samples with different modes must both be correct with no extra bubble.
- Reset: xout=0, yout=0, valid=0, busy=0. All internal valid bits clear, which discards in-flight samples. Reset has priority over en.
- reset and en high in the same cycle: reset wins and the input sample is dropped.
- Out-of-range inputs (>= Q): the result is undefined, but valid timing is unaffected.

Test Plan:
- CT basic, Q=12289: x=1, y=2, w=3, mode=0, one en pulse, then en=1 with no new valid samples → after LAT=5 enabled cycles, valid=1, xout=7, yout=12284.
- GS basic: x=5, y=7, w=2, mode=1 → xout=12, yout=12285 (i.e. −4 mod Q), with the same latency of 5.
- Wrap boundary CT: x=y=w=12288 → t=1, xout=0, yout=12287. Also x=0, y=1, w=1 → xout=1, yout=12288.
- Stall: stream 8 CT samples (x=i, y=1, w=1); hold en=0 for 3 cycles after the 3rd sample → outputs and valid frozen during the stall; all 8 results (i+1, i−1 mod Q) appear in order with none lost or duplicated.
- Mixed modes back-to-back: alternate mode 0/1 on consecutive cycles with x=10, y=3, w=4 → CT results 22/12287 and GS results 13/28 interleave correctly at 1 result per cycle.
- Reset mid-flight: issue 3 samples, assert reset for 1 cycle at the 2nd enabled cycle → valid=0, busy=0, xout=yout=0 next cycle; no stale result is ever emitted afterwards. A new sample after reset completes in exactly LAT cycles.
